// File: rtl/b_lut_pkg.sv
// Shared types and sizing helpers for the sequential nibble-wise LUT unit.
package b_lut_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W      = 4;
   localparam int TABLE_ENTRIES = 16;

   typedef struct packed {
      int nstep;
      int cnt_w;
   } step_cfg_t;

   // Number of BUSY steps and the step counter width (at least one bit).
   function automatic step_cfg_t step_cfg(input int xlen, input int lanes);
      step_cfg_t c;
      c.nstep = xlen / (NIBBLE_W * lanes);
      c.cnt_w = (c.nstep > 1) ? $clog2(c.nstep) : 1;
      return c;
   endfunction

endpackage

// File: rtl/b_lut_lane.sv
// Combinational single-nibble lookup: forward table[idx], or inverse smallest i with table[i]==idx.
module b_lut_lane
   import b_lut_pkg::*;
(
   input  logic [TABLE_ENTRIES*NIBBLE_W-1:0] tbl,
   input  logic [NIBBLE_W-1:0]               nib_in,
   input  logic                              inv,
   output logic [NIBBLE_W-1:0]               nib_out,
   output logic                              no_match
);

   logic [NIBBLE_W-1:0] fwd;
   logic [NIBBLE_W-1:0] rev;
   logic                hit;

   always_comb begin
      fwd = '0;
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
         if (nib_in == NIBBLE_W'(i)) fwd = tbl[i*NIBBLE_W +: NIBBLE_W];
      end
   end

   // Scanning downwards lets the lowest matching index win.
   always_comb begin
      rev = '0;
      hit = 1'b0;
      for (int i = TABLE_ENTRIES - 1; i >= 0; i--) begin
         if (tbl[i*NIBBLE_W +: NIBBLE_W] == nib_in) begin
            rev = NIBBLE_W'(i);
            hit = 1'b1;
         end
      end
   end

   assign nib_out  = inv ? rev : fwd;
   assign no_match = inv & ~hit;

endmodule

// File: rtl/b_lut_seq.sv
// Multi-cycle xc.lut: LANES nibbles per cycle, NSTEP cycles from accept to rsp_valid, held until rsp_ready.
// Inverse lookup present only when B_LUT_SEQ_INVERSE_EN is defined; req_ready drops under flush.
module b_lut_seq
   import b_lut_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int LANES = 2
)(
   input  logic            clock,
   input  logic            resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_inv,
   input  logic [XLEN-1:0] rs1,
   input  logic [31:0]     rs2,
   input  logic [31:0]     rs3,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] result,
   output logic            rsp_nonbij
);

   localparam step_cfg_t        CFG   = step_cfg(XLEN, LANES);
   localparam int               NSTEP = CFG.nstep;
   localparam int               CNT_W = CFG.cnt_w;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSTEP - 1);

   state_t                             state_q, state_d;
   logic [CNT_W-1:0]                   cnt_q;
   logic [XLEN-1:0]                    op_q;
   logic [XLEN-1:0]                    result_q;
   logic [TABLE_ENTRIES*NIBBLE_W-1:0]  tbl_q;
   logic                               accept;
   logic                               last_step;
   logic                               inv_eff;
   logic [LANES-1:0][NIBBLE_W-1:0]     lane_in;
   logic [LANES-1:0][NIBBLE_W-1:0]     lane_out;
   logic [LANES-1:0]                   lane_miss;

   assign accept    = req_valid & req_ready;
   assign last_step = (cnt_q == LAST);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (last_step) state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = accept ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & rsp_ready));
      rsp_valid = (state_q == ST_DONE);
   end

   // Steer the nibbles belonging to the current step onto the lanes.
   always_comb begin
      lane_in = '0;
      for (int s = 0; s < NSTEP; s++) begin
         if (cnt_q == CNT_W'(s)) begin
            for (int l = 0; l < LANES; l++) begin
               lane_in[l] = op_q[(s*LANES + l)*NIBBLE_W +: NIBBLE_W];
            end
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      b_lut_lane u_lane (
         .tbl      (tbl_q),
         .nib_in   (lane_in[l]),
         .inv      (inv_eff),
         .nib_out  (lane_out[l]),
         .no_match (lane_miss[l])
      );
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         op_q     <= '0;
         tbl_q    <= '0;
         result_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q    <= '0;
         op_q     <= rs1;
         tbl_q    <= {rs3, rs2};
         result_q <= '0;
      end else if (state_q == ST_BUSY) begin
         cnt_q <= last_step ? '0 : cnt_q + 1'b1;
         for (int s = 0; s < NSTEP; s++) begin
            if (cnt_q == CNT_W'(s)) begin
               for (int l = 0; l < LANES; l++) begin
                  result_q[(s*LANES + l)*NIBBLE_W +: NIBBLE_W] <= lane_out[l];
               end
            end
         end
      end
   end

   assign result = result_q;

`ifdef B_LUT_SEQ_INVERSE_EN
   logic inv_q;
   logic nonbij_q;

   // A single unmatched nibble marks the whole operation as non-bijective.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         inv_q    <= 1'b0;
         nonbij_q <= 1'b0;
      end else if (!flush) begin
         if (accept) begin
            inv_q    <= req_inv;
            nonbij_q <= 1'b0;
         end else if ((state_q == ST_BUSY) && (|lane_miss)) begin
            nonbij_q <= 1'b1;
         end
      end
   end

   assign inv_eff    = inv_q;
   assign rsp_nonbij = nonbij_q;
`else
   logic unused_inv;
   assign unused_inv = req_inv ^ (|lane_miss);
   assign inv_eff    = 1'b0;
   assign rsp_nonbij = 1'b0;
`endif

endmodule

// File: tb/tb_b_lut_seq.sv
// Bench for b_lut_seq: directed literal cases plus random traffic against an operation-level model.
module tb_b_lut_seq;

   localparam int XLEN  = 32;
   localparam int LANES = 2;
   localparam int NSTEP = XLEN / (4 * LANES);

   logic            clock = 1'b0;
   logic            resetn = 1'b1;
   logic            flush = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_inv = 1'b0;
   logic            rsp_ready = 1'b0;
   logic [XLEN-1:0] rs1 = '0;
   logic [31:0]     rs2 = '0;
   logic [31:0]     rs3 = '0;
   logic            req_ready;
   logic            rsp_valid;
   logic            rsp_nonbij;
   logic [XLEN-1:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   b_lut_seq #(.XLEN(XLEN), .LANES(LANES)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_inv    (req_inv),
      .rs1        (rs1),
      .rs2        (rs2),
      .rs3        (rs3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .result     (result),
      .rsp_nonbij (rsp_nonbij)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Operation-level reference: returns {nonbij, result}.
   function automatic logic [XLEN:0] ref_lut(input logic [XLEN-1:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input bit inv);
      logic [3:0]      t [16];
      logic [XLEN-1:0] r;
      logic [3:0]      v;
      logic [3:0]      o;
      int              hit;
      bit              nb;
      r  = '0;
      nb = 1'b0;
      for (int i = 0; i < 8; i++) begin
         t[i]     = b[4*i +: 4];
         t[i + 8] = c[4*i +: 4];
      end
      for (int n = 0; n < XLEN/4; n++) begin
         v = a[4*n +: 4];
         o = t[v];
`ifdef B_LUT_SEQ_INVERSE_EN
         if (inv) begin
            hit = -1;
            for (int i = 15; i >= 0; i--) if (t[i] == v) hit = i;
            if (hit < 0) begin
               o  = 4'h0;
               nb = 1'b1;
            end else begin
               o = 4'(hit);
            end
         end
`else
         hit = 0;
         if (inv) o = t[v + 4'(hit)];
`endif
         r[4*n +: 4] = o;
      end
      return {nb, r};
   endfunction

   // Model state: one outstanding operation whose response is due at edge 'due'.
   bit              have = 1'b0;
   int              cyc = 0;
   int              due = 0;
   logic [XLEN-1:0] exp_res = '0;
   bit              exp_nb = 1'b0;

   always @(posedge clock or negedge resetn) begin
      bit vld;
      bit rr;
      if (!resetn) begin
         have = 1'b0;
         cyc  = 0;
         due  = 0;
      end else begin
         vld = have && (cyc >= due);
         rr  = !flush && (!have || (vld && rsp_ready));
         cyc++;
         if (flush) begin
            have = 1'b0;
         end else begin
            if (vld && rsp_ready) have = 1'b0;
            if (req_valid && rr) begin
               {exp_nb, exp_res} = ref_lut(rs1, rs2, rs3, req_inv);
               have = 1'b1;
               due  = cyc + NSTEP;
            end
         end
      end
   end

   always @(negedge clock) begin
      bit vld;
      if (resetn) begin
         vld = have && (cyc >= due);
         check("rsp_valid", rsp_valid, vld);
         check("req_ready", req_ready, !flush && (!have || (vld && rsp_ready)));
         if (vld) begin
            check("result", result, exp_res);
            check("rsp_nonbij", rsp_nonbij, exp_nb);
         end
      end
   end

   task automatic scramble();
      rs1     = $urandom;
      rs2     = $urandom;
      rs3     = $urandom;
      req_inv = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit inv);
      @(posedge clock); #1;
      rs1 = a; rs2 = b; rs3 = c; req_inv = inv; req_valid = 1'b1;
      for (int k = 0; k < 20 && !req_ready; k++) begin
         @(posedge clock); #1;
      end
      check("send_ready", req_ready, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      scramble();
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check("consume_valid", rsp_valid, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      #2 resetn = 1'b0;
      #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_result", result, 0);
      check("rst_nonbij", rsp_nonbij, 0);
      check("rst_ready", req_ready, 1);
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;

      send(32'h12345678, 32'h76543210, 32'hFEDCBA98, 1'b0);
      wait_rsp(lat);
      check("ident_latency", lat, 4);
      check("ident_result", result, 32'h12345678);
      check("ident_nonbij", rsp_nonbij, 0);
      repeat (3) begin
         @(posedge clock); #1;
         check("stall_result", result, 32'h12345678);
         check("stall_ready", req_ready, 0);
         check("stall_valid", rsp_valid, 1);
      end

      rs1 = 32'h12345678; rs2 = 32'h89ABCDEF; rs3 = 32'h01234567; req_inv = 1'b0;
      req_valid = 1'b1; rsp_ready = 1'b1;
      #1 check("b2b_ready", req_ready, 1);
      @(posedge clock); #1;
      req_valid = 1'b0; rsp_ready = 1'b0;
      scramble();
      check("b2b_busy", rsp_valid, 0);
      wait_rsp(lat);
      check("b2b_latency", lat, 4);
      check("rev_result", result, 32'hEDCBA987);
      consume();

      send(32'hEDCBA987, 32'h89ABCDEF, 32'h01234567, 1'b1);
      wait_rsp(lat);
      check("inv_latency", lat, 4);
      check("inv_result", result, 32'h12345678);
      check("inv_nonbij", rsp_nonbij, 0);
      consume();

      send(32'h00000001, 32'h0, 32'h0, 1'b1);
      wait_rsp(lat);
      check("zero_result", result, 32'h0);
`ifdef B_LUT_SEQ_INVERSE_EN
      check("zero_nonbij", rsp_nonbij, 1);
`else
      check("zero_nonbij", rsp_nonbij, 0);
`endif
      consume();

      send(32'h12345678, 32'h76543210, 32'hFEDCBA98, 1'b0);
      @(posedge clock); #1;
      resetn = 1'b0;
      #1;
      check("midrst_valid", rsp_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_nonbij", rsp_nonbij, 0);
      check("midrst_ready", req_ready, 1);
      @(posedge clock); #1 resetn = 1'b1;
      repeat (8) begin
         @(posedge clock); #1;
         check("midrst_norsp", rsp_valid, 0);
      end

      send(32'hCAFEF00D, 32'h76543210, 32'hFEDCBA98, 1'b0);
      wait_rsp(lat);
      check("flush_pre_valid", rsp_valid, 1);
      flush = 1'b1; req_valid = 1'b1;
      #1 check("flush_ready", req_ready, 0);
      @(posedge clock); #1;
      flush = 1'b0; req_valid = 1'b0;
      repeat (6) begin
         check("flush_norsp", rsp_valid, 0);
         @(posedge clock); #1;
      end

      for (int i = 0; i < 3000; i++) begin
         @(posedge clock); #1;
         resetn    = ($urandom_range(0, 400) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         req_valid = ($urandom_range(0, 1) == 1);
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_inv   = 1'($urandom_range(0, 1));
         rs1       = $urandom;
         case ($urandom_range(0, 3))
            0: begin rs2 = 32'h76543210; rs3 = 32'hFEDCBA98; end
            1: begin rs2 = 32'h89ABCDEF; rs3 = 32'h01234567; end
            2: begin rs2 = 32'h3C1A5E07; rs3 = 32'hB2D9F846; end
            default: begin rs2 = $urandom; rs3 = $urandom; end
         endcase
      end

      @(posedge clock); #1;
      resetn = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
